// File: rtl/cva5_config.sv
// cva5_config: build-time configuration constants shared across the core.
//   WB_PORTS_MAX : upper bound on writeback sources feeding the register bank.
package cva5_config;
  localparam int unsigned WB_PORTS_MAX = 8;
endpackage

// File: rtl/cva5_types.sv
// cva5_types: common type definitions.
//   phys_addr_t  : physical register index (64 registers).
//   wb_port_id_t : index of a writeback source, sized for WB_PORTS_MAX.
package cva5_types;
  import cva5_config::*;

  typedef logic [5:0] phys_addr_t;
  typedef logic [$clog2(WB_PORTS_MAX)-1:0] wb_port_id_t;
endpackage

// File: rtl/regfile_writeback_arbiter_rr.sv
// wb_rr_arbiter: round-robin arbiter over NUM_PORTS requesters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : request vector
//   grant        : one-hot grant (combinational, 0 while in reset)
//   grant_idx    : index of the granted requester
//   grant_valid  : a grant is issued this cycle
// The priority pointer moves to one past the granted port and holds when idle.
module wb_rr_arbiter
  import cva5_config::*;
  import cva5_types::*;
#(
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output wb_port_id_t          grant_idx,
  output logic                 grant_valid
);

  wb_port_id_t rr_ptr_q, rr_ptr_d;

  // Two passes: first the ports at or above the pointer, then a wrap-around
  // pass over all ports that only takes effect if the first found nothing.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!grant_valid && rst_n && req[p] && (p >= int'(rr_ptr_q))) begin
        grant[p]    = 1'b1;
        grant_idx   = wb_port_id_t'(p);
        grant_valid = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!grant_valid && rst_n && req[p]) begin
        grant[p]    = 1'b1;
        grant_idx   = wb_port_id_t'(p);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      if (int'(grant_idx) == int'(NUM_PORTS) - 1) rr_ptr_d = '0;
      else                                        rr_ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: selects one completed writeback result per cycle
// (round-robin) and drives the register bank write port through one register
// stage. Writes to physical register 0 are acknowledged but never committed.
//   clk, rst_n              : clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data: writeback sources; held until wb_ack
//   wb_ack                  : one-hot accept, combinational
//   write_addr/new_data/commit : register bank write port (registered)
//   read_addr/rf_data/data  : issue read bypass, present only when
//                             RF_WB_BYPASS_EN is defined
module regfile_writeback_arbiter
  import cva5_config::*;
  import cva5_types::*;
#(
  parameter int unsigned NUM_WB_PORTS   = 3,
  parameter int unsigned NUM_READ_PORTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_WB_PORTS-1:0] wb_valid,
  input  phys_addr_t              wb_addr [NUM_WB_PORTS],
  input  logic [31:0]             wb_data [NUM_WB_PORTS],
  output logic [NUM_WB_PORTS-1:0] wb_ack,
  output phys_addr_t              write_addr,
  output logic [31:0]             new_data,
  output logic                    commit
`ifdef RF_WB_BYPASS_EN
  ,
  input  phys_addr_t              read_addr [NUM_READ_PORTS],
  input  logic [31:0]             rf_data   [NUM_READ_PORTS],
  output logic [31:0]             data      [NUM_READ_PORTS]
`endif
);

  if (NUM_WB_PORTS < 2 || NUM_WB_PORTS > WB_PORTS_MAX) begin : g_bad_wb_ports
    $error("NUM_WB_PORTS out of range");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_read_ports
    $error("NUM_READ_PORTS must be at least 1");
  end

  logic [NUM_WB_PORTS-1:0] grant;
  wb_port_id_t             grant_idx;
  logic                    grant_valid;

  wb_rr_arbiter #(
    .NUM_PORTS (NUM_WB_PORTS)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (wb_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign wb_ack = grant;

  phys_addr_t  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_WB_PORTS; i++) begin
      if (wb_port_id_t'(i) == grant_idx) begin
        sel_addr = wb_addr[i];
        sel_data = wb_data[i];
      end
    end
  end

  phys_addr_t  write_addr_q, write_addr_d;
  logic [31:0] new_data_q, new_data_d;
  logic        commit_q, commit_d;

  always_comb begin
    write_addr_d = write_addr_q;
    new_data_d   = new_data_q;
    commit_d     = 1'b0;
    if (grant_valid) begin
      write_addr_d = sel_addr;
      new_data_d   = sel_data;
      commit_d     = (sel_addr != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_addr_q <= '0;
      new_data_q   <= '0;
      commit_q     <= 1'b0;
    end else begin
      write_addr_q <= write_addr_d;
      new_data_q   <= new_data_d;
      commit_q     <= commit_d;
    end
  end

  assign write_addr = write_addr_q;
  assign new_data   = new_data_q;
  assign commit     = commit_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the write still in flight to the bank; register 0 never matches
  // because commit is never raised for it.
  always_comb begin
    for (int unsigned j = 0; j < NUM_READ_PORTS; j++) begin
      data[j] = (commit_q && (write_addr_q == read_addr[j])) ? new_data_q : rf_data[j];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  import cva5_types::*;

  localparam int N  = 3;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     wb_valid;
  phys_addr_t       wb_addr [N];
  logic [31:0]      wb_data [N];
  logic [N-1:0]     wb_ack;
  phys_addr_t       write_addr;
  logic [31:0]      new_data;
  logic             commit;
`ifdef RF_WB_BYPASS_EN
  phys_addr_t       read_addr [NR];
  logic [31:0]      rf_data   [NR];
  logic [31:0]      data      [NR];
`endif

  regfile_writeback_arbiter #(
    .NUM_WB_PORTS   (N),
    .NUM_READ_PORTS (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ack     (wb_ack),
    .write_addr (write_addr),
    .new_data   (new_data),
    .commit     (commit)
`ifdef RF_WB_BYPASS_EN
    ,
    .read_addr  (read_addr),
    .rf_data    (rf_data),
    .data       (data)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: pointer and the registered write port.
  int          m_ptr;
  logic        m_commit;
  phys_addr_t  m_addr;
  logic [31:0] m_data;
  int          last_g;
  int          n_vec = 0;
  int          n_err = 0;
  int          seq [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_commit = 1'b0; m_addr = '0; m_data = '0; last_g = -1;
  endtask

  // Winner = valid port with the smallest forward distance from the pointer.
  function automatic int pick();
    int best = -1;
    int bd   = N;
    for (int p = 0; p < N; p++) begin
      if (wb_valid[p]) begin
        int d = (p - m_ptr + N) % N;
        if (d < bd) begin bd = d; best = p; end
      end
    end
    return best;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic do_cycle(input string tag);
    int g;
    logic [N-1:0] eack;
    #1;
    g = pick();
    eack = '0;
    if (g >= 0) eack[g] = 1'b1;
    check({tag, " ack"},    32'(wb_ack),     32'(eack));
    check({tag, " commit"}, 32'(commit),     32'(m_commit));
    check({tag, " waddr"},  32'(write_addr), 32'(m_addr));
    check({tag, " wdata"},  new_data,        m_data);
`ifdef RF_WB_BYPASS_EN
    for (int j = 0; j < NR; j++)
      check({tag, " bypass"}, data[j],
            (m_commit && m_addr == read_addr[j]) ? m_data : rf_data[j]);
`endif
    @(posedge clk);
    if (g >= 0) begin
      m_commit = (wb_addr[g] != 0);
      m_addr   = wb_addr[g];
      m_data   = wb_data[g];
      m_ptr    = (g + 1) % N;
    end else begin
      m_commit = 1'b0;
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_valid = '1;
    for (int i = 0; i < N; i++) begin wb_addr[i] = 6'(i + 1); wb_data[i] = 32'(i); end
`ifdef RF_WB_BYPASS_EN
    for (int j = 0; j < NR; j++) begin read_addr[j] = '0; rf_data[j] = '0; end
`endif
    model_reset();
    #12;
    check("reset ack",    32'(wb_ack),     0);
    check("reset commit", 32'(commit),     0);
    check("reset waddr",  32'(write_addr), 0);
    check("reset wdata",  new_data,        0);
    @(negedge clk);
    wb_valid = '0;
    rst_n    = 1'b1;

    // Single source
    wb_valid = 3'b010; wb_addr[1] = 6'd5; wb_data[1] = 32'hDEADBEEF;
    do_cycle("single");
    wb_valid = '0;
    check("single commit", 32'(commit), 1);
    check("single waddr",  32'(write_addr), 5);
    check("single wdata",  new_data, 32'hDEADBEEF);
    do_cycle("single idle");
    check("single commit low", 32'(commit), 0);

    // All three valid from reset, each drops after ack
    pulse_reset();
    wb_valid = 3'b111;
    for (int i = 0; i < N; i++) begin wb_addr[i] = 6'(i + 1); wb_data[i] = $urandom; end
    for (int k = 0; k < 3; k++) begin
      do_cycle("all3");
      seq[k] = last_g;
      if (last_g >= 0) wb_valid[last_g] = 1'b0;
    end
    for (int k = 0; k < 3; k++) check("all3 order", 32'(seq[k]), 32'(k));
    check("all3 last addr", 32'(write_addr), 3);
    wb_valid = 3'b111;
    do_cycle("all3 wrap");
    check("all3 wrap port", 32'(last_g), 0);
    wb_valid = '0;
    do_cycle("idle");

    // Zero register
    wb_valid = 3'b001; wb_addr[0] = '0; wb_data[0] = 32'h1234;
    do_cycle("zero");
    wb_valid = '0;
    check("zero commit", 32'(commit), 0);
    check("zero waddr",  32'(write_addr), 0);
    do_cycle("zero idle");

    // Fairness between ports 0 and 2
    pulse_reset();
    wb_valid = 3'b101;
    wb_addr[0] = 6'd10; wb_addr[2] = 6'd12;
    for (int k = 0; k < 6; k++) begin
      do_cycle("fair");
      seq[k] = last_g;
    end
    for (int k = 0; k < 6; k++) check("fair order", 32'(seq[k]), (k % 2 == 0) ? 0 : 2);
    wb_valid = '0;
    do_cycle("idle");

    // Reset while a write is registered
    wb_valid = 3'b010; wb_addr[1] = 6'd9; wb_data[1] = 32'hCAFEF00D;
    do_cycle("rst pre");
    check("rst pre commit", 32'(commit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst commit", 32'(commit), 0);
    check("rst waddr",  32'(write_addr), 0);
    check("rst wdata",  new_data, 0);
    check("rst ack",    32'(wb_ack), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wb_valid = 3'b111;
    do_cycle("rst post");
    check("rst post port", 32'(last_g), 0);
    wb_valid = '0;
    do_cycle("idle");

`ifdef RF_WB_BYPASS_EN
    wb_valid = 3'b001; wb_addr[0] = 6'd7; wb_data[0] = 32'hA5A5A5A5;
    do_cycle("byp load");
    wb_valid = '0;
    read_addr[0] = 6'd7; read_addr[1] = 6'd8;
    rf_data[0] = 32'h11111111; rf_data[1] = 32'h22222222;
    #1;
    check("byp data0", data[0], 32'hA5A5A5A5);
    check("byp data1", data[1], 32'h22222222);
    @(negedge clk);
    m_commit = 1'b0;
    check("byp nocommit", data[0], 32'h11111111);
`endif

    // Randomized traffic: sources hold until acked
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wb_valid[i] || last_g == i) begin
          wb_valid[i] = ($urandom % 3) != 0;
          wb_addr[i]  = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom);
          wb_data[i]  = $urandom;
        end
      end
`ifdef RF_WB_BYPASS_EN
      for (int j = 0; j < NR; j++) begin
        read_addr[j] = 6'($urandom % 8) | (m_addr & 6'h38);
        rf_data[j]   = $urandom;
      end
`endif
      do_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
